// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control blocks.
// Contents:
//   TUSE_NONE              - tUse code meaning "operand not read"
//   FWD_RF/FWD_MEM/FWD_EX  - ID-stage forward select codes
//   MD_KIND_MULT/DIV       - mult/div family selector
//   sb_slot_t              - one scoreboard slot (destination, tNew, write enable)
//   dec()                  - decrement that stops at zero
package pipeline_ctrl_pkg;

  localparam logic [2:0] TUSE_NONE    = 3'h7;

  localparam logic [1:0] FWD_RF       = 2'd0;
  localparam logic [1:0] FWD_MEM      = 2'd1;
  localparam logic [1:0] FWD_EX       = 2'd2;

  localparam logic       MD_KIND_MULT = 1'b0;
  localparam logic       MD_KIND_DIV  = 1'b1;

  typedef struct packed {
    logic [4:0] dst;
    logic [2:0] tnew;
    logic       we;
  } sb_slot_t;

  function automatic logic [2:0] dec(input logic [2:0] x);
    return (x == 3'd0) ? 3'd0 : x - 3'd1;
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Busy counter for the multi-cycle mult/div unit.
// Ports:
//   clk, resetN  - clock, synchronous active-low reset
//   load         - load loadValue on this edge (takes priority over counting down)
//   loadValue    - number of busy cycles to load
//   count        - current remaining busy cycles
//   busy         - count is non-zero
module md_busy_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             load,
  input  logic [CNT_W-1:0] loadValue,
  output logic [CNT_W-1:0] count,
  output logic             busy
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= loadValue;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count = r_count;
  assign busy  = (r_count != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush generator for the 5-stage pipeline. A shadow scoreboard of the
// EX and MEM stages (destination, tNew, write enable) is compared against the
// tUse of the ID-stage operands; the mult/div busy counter adds a structural
// stall for HI/LO users. Also produces ID-stage forward selects and a
// saturating stall-cycle counter.
// Ports:
//   clk, resetN            - clock, synchronous active-low reset
//   rsInID/rtInID          - source registers of the instruction in ID
//   tUseRsInID/tUseRtInID  - cycles until each source is needed (7 = unused)
//   regFinalDstInID, regWriteEnabledInID, tNewInID - result info of ID instr
//   mdStartInID, mdKindInID, mdUseInID             - mult/div info of ID instr
//   stallOf_IF_ID, pcEnable, resetOf_ID_EX         - pipeline control
//   fwdRsSelInID/fwdRtSelInID                      - 0 RF, 1 MEM, 2 EX
//   mdBusy                 - mult/div unit busy
//   stallCycleCount        - saturating number of stalled cycles
module hazard_stall_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int MD_CNT_W    = 4,
  parameter int STALL_CNT_W = 32  // internal width of the stall counter (<= 32)
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [4:0]  rsInID,
  input  logic [4:0]  rtInID,
  input  logic [2:0]  tUseRsInID,
  input  logic [2:0]  tUseRtInID,
  input  logic [4:0]  regFinalDstInID,
  input  logic        regWriteEnabledInID,
  input  logic [2:0]  tNewInID,
  input  logic        mdStartInID,
  input  logic        mdKindInID,
  input  logic        mdUseInID,
  output logic        stallOf_IF_ID,
  output logic        pcEnable,
  output logic        resetOf_ID_EX,
  output logic [1:0]  fwdRsSelInID,
  output logic [1:0]  fwdRtSelInID,
  output logic        mdBusy,
  output logic [31:0] stallCycleCount
);

  sb_slot_t               r_ex;
  sb_slot_t               r_mem;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic                   w_haz_rs;
  logic                   w_haz_rt;
  logic                   w_md_busy;
  logic                   w_md_stall;
  logic                   w_stall;
  logic                   w_md_load;
  logic [MD_CNT_W-1:0]    w_md_load_val;
  logic [MD_CNT_W-1:0]    w_md_count;

  // A slot blocks an operand when it will still be producing the value after
  // the operand is needed.
  function automatic logic slot_blocks(input sb_slot_t s, input logic [4:0] src,
                                       input logic [2:0] tuse);
    return s.we && (s.dst == src) && (s.tnew > tuse);
  endfunction

  function automatic logic operand_hazard(input logic [4:0] src, input logic [2:0] tuse,
                                          input sb_slot_t ex, input sb_slot_t mem);
    return (src != 5'd0) && (tuse != TUSE_NONE) &&
           (slot_blocks(ex, src, tuse) || slot_blocks(mem, src, tuse));
  endfunction

  // Youngest producer (EX) wins over MEM; $0 is never forwarded.
  function automatic logic [1:0] operand_fwd(input logic [4:0] src,
                                             input sb_slot_t ex, input sb_slot_t mem);
    if (src == 5'd0)                                     return FWD_RF;
    if (ex.we && ex.dst == src && ex.tnew == 3'd0)       return FWD_EX;
    if (mem.we && mem.dst == src && mem.tnew == 3'd0)    return FWD_MEM;
    return FWD_RF;
  endfunction

  assign w_haz_rs   = operand_hazard(rsInID, tUseRsInID, r_ex, r_mem);
  assign w_haz_rt   = operand_hazard(rtInID, tUseRtInID, r_ex, r_mem);
  assign w_md_stall = mdUseInID & w_md_busy;
  assign w_stall    = w_haz_rs | w_haz_rt | w_md_stall;

  // A start only launches the unit when the instruction actually leaves ID.
  assign w_md_load     = mdStartInID & ~w_stall;
  assign w_md_load_val = (mdKindInID == MD_KIND_DIV) ? MD_CNT_W'(DIV_CYCLES)
                                                     : MD_CNT_W'(MULT_CYCLES);

  md_busy_counter #(.CNT_W(MD_CNT_W)) u_md_cnt (
    .clk       (clk),
    .resetN    (resetN),
    .load      (w_md_load),
    .loadValue (w_md_load_val),
    .count     (w_md_count),
    .busy      (w_md_busy)
  );

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_mem.dst  <= r_ex.dst;
      r_mem.tnew <= dec(r_ex.tnew);
      r_mem.we   <= r_ex.we;
      if (w_stall) begin
        r_ex <= '0;
      end else begin
        r_ex.dst  <= regFinalDstInID;
        r_ex.tnew <= dec(tNewInID);
        r_ex.we   <= regWriteEnabledInID;
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  // While reset is held the pipeline is flushed and never frozen.
  always_comb begin
    stallOf_IF_ID = 1'b0;
    pcEnable      = 1'b1;
    resetOf_ID_EX = 1'b1;
    fwdRsSelInID  = FWD_RF;
    fwdRtSelInID  = FWD_RF;
    mdBusy        = 1'b0;
    if (resetN) begin
      stallOf_IF_ID = w_stall;
      pcEnable      = ~w_stall;
      resetOf_ID_EX = w_stall;
      fwdRsSelInID  = operand_fwd(rsInID, r_ex, r_mem);
      fwdRtSelInID  = operand_fwd(rtInID, r_ex, r_mem);
      mdBusy        = w_md_busy;
    end
  end

  assign stallCycleCount = 32'(r_stall_cnt);

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        resetN;
  logic [4:0]  rsInID, rtInID, regFinalDstInID;
  logic [2:0]  tUseRsInID, tUseRtInID, tNewInID;
  logic        regWriteEnabledInID, mdStartInID, mdKindInID, mdUseInID;
  logic        stallOf_IF_ID, pcEnable, resetOf_ID_EX, mdBusy;
  logic [1:0]  fwdRsSelInID, fwdRtSelInID;
  logic [31:0] stallCycleCount;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .MD_CNT_W(4),
                      .STALL_CNT_W(CNT_W)) dut (
    .clk(clk), .resetN(resetN),
    .rsInID(rsInID), .rtInID(rtInID),
    .tUseRsInID(tUseRsInID), .tUseRtInID(tUseRtInID),
    .regFinalDstInID(regFinalDstInID), .regWriteEnabledInID(regWriteEnabledInID),
    .tNewInID(tNewInID), .mdStartInID(mdStartInID), .mdKindInID(mdKindInID),
    .mdUseInID(mdUseInID), .stallOf_IF_ID(stallOf_IF_ID), .pcEnable(pcEnable),
    .resetOf_ID_EX(resetOf_ID_EX), .fwdRsSelInID(fwdRsSelInID),
    .fwdRtSelInID(fwdRtSelInID), .mdBusy(mdBusy), .stallCycleCount(stallCycleCount)
  );

  // ---------------- scoreboard / checker ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Every instruction that left ID is remembered with the cycle it left.
  // Its result is "remaining" cycles away: tNew minus its age, floored at 0.
  // It is visible to hazard/forward logic while age is 1 (EX) or 2 (MEM).
  typedef struct {
    logic [4:0] dst;
    bit         we;
    int         tnew;
    int         ic;
  } rec_t;

  rec_t q[$];
  int   n = 0;
  int   md_until = -1;
  int   m_cnt = 0;

  function automatic int remaining(rec_t r);
    int v;
    v = r.tnew - (n - r.ic);
    return (v < 0) ? 0 : v;
  endfunction

  function automatic bit src_hazard(logic [4:0] src, int tuse);
    if (src == 0 || tuse == 7) return 1'b0;
    foreach (q[i]) begin
      if ((n - q[i].ic) >= 1 && (n - q[i].ic) <= 2 && q[i].we &&
          q[i].dst == src && remaining(q[i]) > tuse) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [1:0] src_fwd(logic [4:0] src);
    if (src == 0) return 2'd0;
    foreach (q[i])
      if ((n - q[i].ic) == 1 && q[i].we && q[i].dst == src && remaining(q[i]) == 0)
        return 2'd2;
    foreach (q[i])
      if ((n - q[i].ic) == 2 && q[i].we && q[i].dst == src && remaining(q[i]) == 0)
        return 2'd1;
    return 2'd0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_cycle(input logic [4:0] rs, input logic [4:0] rt,
                          input int tur, input int tut,
                          input logic [4:0] dst, input bit we, input int tnew,
                          input bit mds, input bit mdk, input bit mdu,
                          output bit obs_stall);
    bit         e_stall, e_busy;
    logic [1:0] e_frs, e_frt;
    @(negedge clk);
    resetN = 1'b1;
    rsInID = rs; rtInID = rt;
    tUseRsInID = 3'(tur); tUseRtInID = 3'(tut);
    regFinalDstInID = dst; regWriteEnabledInID = we; tNewInID = 3'(tnew);
    mdStartInID = mds; mdKindInID = mdk; mdUseInID = mdu;
    #1;
    e_busy  = (n <= md_until);
    e_stall = src_hazard(rs, tur) || src_hazard(rt, tut) || (mdu && e_busy);
    e_frs   = src_fwd(rs);
    e_frt   = src_fwd(rt);
    check_val("stall",     32'(stallOf_IF_ID),   32'(e_stall));
    check_val("pcEnable",  32'(pcEnable),        32'(!e_stall));
    check_val("flush",     32'(resetOf_ID_EX),   32'(e_stall));
    check_val("fwdRs",     32'(fwdRsSelInID),    32'(e_frs));
    check_val("fwdRt",     32'(fwdRtSelInID),    32'(e_frt));
    check_val("mdBusy",    32'(mdBusy),          32'(e_busy));
    exp_q.push_back(32'(m_cnt));
    check_val("stallCnt",  stallCycleCount,      exp_q.pop_front());
    obs_stall = stallOf_IF_ID;
    @(posedge clk);
    if (!e_stall) begin
      q.push_back('{dst: dst, we: we, tnew: tnew, ic: n});
      if (mds) md_until = n + (mdk ? 10 : 5);
    end else if (m_cnt < CNT_MAX) begin
      m_cnt++;
    end
    n++;
    while (q.size() > 0 && (n - q[0].ic) > 2) void'(q.pop_front());
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    resetN = 1'b0;
    rsInID = 5'($urandom_range(1, 3)); rtInID = 5'($urandom_range(1, 3));
    tUseRsInID = 3'd0; tUseRtInID = 3'd0; mdUseInID = 1'b1;
    mdStartInID = 1'b0; mdKindInID = 1'b0;
    #1;
    check_val("rst_stall", 32'(stallOf_IF_ID), 32'd0);
    check_val("rst_pcEn",  32'(pcEnable),      32'd1);
    check_val("rst_flush", 32'(resetOf_ID_EX), 32'd1);
    check_val("rst_fwdRs", 32'(fwdRsSelInID),  32'd0);
    check_val("rst_fwdRt", 32'(fwdRtSelInID),  32'd0);
    check_val("rst_busy",  32'(mdBusy),        32'd0);
    @(posedge clk);
    q.delete();
    md_until = -1;
    m_cnt = 0;
    n++;
  endtask

  // Keep presenting the same reader until it leaves ID; returns stalls seen.
  task automatic hold_reader(input logic [4:0] rs, input int tur, input bit mdu,
                             output int stalls);
    bit st;
    stalls = 0;
    for (int k = 0; k < 20; k++) begin
      do_cycle(rs, 5'd0, tur, 7, 5'd9, 1'b1, 1, 1'b0, 1'b0, mdu, st);
      if (!st) return;
      stalls++;
    end
    check_val("reader_timeout", 32'(stalls), 32'hFFFF_FFFF);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit st;
    int stalls;
    int r1, r2;
    resetN = 1'b0;
    rsInID = '0; rtInID = '0; tUseRsInID = 3'd7; tUseRtInID = 3'd7;
    regFinalDstInID = '0; regWriteEnabledInID = 1'b0; tNewInID = '0;
    mdStartInID = 1'b0; mdKindInID = 1'b0; mdUseInID = 1'b0;
    reset_cycle();
    reset_cycle();
    do_cycle(5'd0, 5'd0, 7, 7, 5'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0, st);
    check_val("post_reset_cnt", stallCycleCount, 32'd0);

    // lw $1 then addu reading $1 at tUse 1: one stall
    do_cycle(5'd0, 5'd0, 7, 7, 5'd1, 1'b1, 3, 1'b0, 1'b0, 1'b0, st);
    hold_reader(5'd1, 1, 1'b0, stalls);
    check_val("lw_addu_stalls", 32'(stalls), 32'd1);
    check_val("lw_addu_cnt", stallCycleCount, 32'd1);

    // lw $1 then beq reading $1 at tUse 0: two stalls
    do_cycle(5'd0, 5'd0, 7, 7, 5'd1, 1'b1, 3, 1'b0, 1'b0, 1'b0, st);
    hold_reader(5'd1, 0, 1'b0, stalls);
    check_val("lw_beq_stalls", 32'(stalls), 32'd2);

    // addu $2 (tNew 1), subu reading $2 (tUse 1) no stall, then EX forward
    do_cycle(5'd0, 5'd0, 7, 7, 5'd2, 1'b1, 1, 1'b0, 1'b0, 1'b0, st);
    do_cycle(5'd2, 5'd0, 1, 7, 5'd3, 1'b1, 1, 1'b0, 1'b0, 1'b0, st);
    check_val("addu_subu_nostall", 32'(st), 32'd0);
    do_cycle(5'd0, 5'd0, 7, 7, 5'd2, 1'b1, 1, 1'b0, 1'b0, 1'b0, st);
    do_cycle(5'd0, 5'd0, 7, 7, 5'd4, 1'b1, 1, 1'b0, 1'b0, 1'b0, st);
    // writes to $0 never stall or forward
    do_cycle(5'd0, 5'd0, 7, 7, 5'd0, 1'b1, 3, 1'b0, 1'b0, 1'b0, st);
    do_cycle(5'd0, 5'd0, 0, 0, 5'd5, 1'b1, 1, 1'b0, 1'b0, 1'b0, st);
    check_val("r0_nostall", 32'(st), 32'd0);

    // div then mflo: ten stall cycles
    do_cycle(5'd0, 5'd0, 7, 7, 5'd0, 1'b0, 0, 1'b1, 1'b1, 1'b1, st);
    hold_reader(5'd0, 7, 1'b1, stalls);
    check_val("div_mflo_stalls", 32'(stalls), 32'd10);
    // mult then mfhi: five stall cycles
    do_cycle(5'd0, 5'd0, 7, 7, 5'd0, 1'b0, 0, 1'b1, 1'b0, 1'b1, st);
    hold_reader(5'd0, 7, 1'b1, stalls);
    check_val("mult_mfhi_stalls", 32'(stalls), 32'd5);

    // reset in the middle of an md stall with $5 in flight
    do_cycle(5'd0, 5'd0, 7, 7, 5'd5, 1'b1, 3, 1'b0, 1'b0, 1'b0, st);
    do_cycle(5'd0, 5'd0, 7, 7, 5'd0, 1'b0, 0, 1'b1, 1'b1, 1'b1, st);
    do_cycle(5'd5, 5'd0, 0, 7, 5'd0, 1'b0, 0, 1'b0, 1'b0, 1'b1, st);
    do_cycle(5'd5, 5'd0, 0, 7, 5'd0, 1'b0, 0, 1'b0, 1'b0, 1'b1, st);
    reset_cycle();
    do_cycle(5'd5, 5'd0, 0, 7, 5'd0, 1'b0, 0, 1'b0, 1'b0, 1'b1, st);
    check_val("rst_mid_stall", 32'(st), 32'd0);
    check_val("rst_mid_busy", 32'(mdBusy), 32'd0);
    check_val("rst_mid_cnt", stallCycleCount, 32'd0);

    // randomized traffic with small register numbers to provoke hazards
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_cycle();
      end else begin
        bit mds, mdu;
        r1 = $urandom_range(0, 3);
        r2 = $urandom_range(0, 3);
        mds = ($urandom_range(0, 7) == 0);
        mdu = mds || ($urandom_range(0, 5) == 0);
        do_cycle(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 (r1 == 3) ? 7 : r1, (r2 == 3) ? 7 : r2,
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), mds, 1'($urandom_range(0, 1)), mdu, st);
      end
    end

    // saturation of the stall counter: more than CNT_MAX stalls after reset
    reset_cycle();
    for (int k = 0; k < 2; k++) begin
      do_cycle(5'd0, 5'd0, 7, 7, 5'd0, 1'b0, 0, 1'b1, 1'b1, 1'b1, st);
      hold_reader(5'd0, 7, 1'b1, stalls);
    end
    do_cycle(5'd0, 5'd0, 7, 7, 5'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0, st);
    check_val("cnt_saturated", stallCycleCount, 32'(CNT_MAX));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
